switch_input_port: RTL
======================

// Module: switch_input_port
// PURPOSE
//  Input-side peer of the 7-segment output path. Serves the processor's IN instruction:
//  on request, waits for an operator press of the enter key, samples the 15 board switches,
//  and returns a sign-extended 32-bit word with a one-cycle valid strobe.
//  Sits between the board pins (switches, enter key) and the processor's IN_Data / stall logic.
// PARAMETERS
//  SW_WIDTH         15      number of switch inputs
//  DATA_WIDTH       32      width of the word returned to the processor
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles before a key level is accepted (10 ms @ 50 MHz)
//  SIGN_EXTEND      1       1: replicate switches[SW_WIDTH-1] into the upper bits; 0: zero-extend
// PORTS
//  clock      in   1           system clock; all logic on its rising edge
//  reset      in   1           synchronous reset, active-high
//  enter      in   1           raw enter push-button, active-low, asynchronous to clock
//  switches   in   SW_WIDTH    raw switch levels, asynchronous to clock
//  in_req     in   1           processor requests an input word; level, held until in_valid
//  in_valid   out  1           one-cycle strobe: dataIN holds the captured word
//  dataIN     out  DATA_WIDTH  captured word; stable until the next capture
//  waiting    out  1           high while a request is pending (drives the board LED)
// BEHAVIOUR
//  Reset values: in_valid=0, dataIN=0, waiting=0, FSM=IDLE, synchronisers=released level (1),
//    debounced key=released, debounce counter=0.
//  Synchronisation: enter and switches each pass through 2 flops before any use.
//  Debounce: the counter resets on every change of the synchronised key. After DEBOUNCE_CYCLES
//    equal samples the debounced level updates. press = one-cycle pulse on the debounced 1->0 edge.
//    Only one press pulse per physical press; a held key never repeats.
//  FSM:
//   IDLE    : waiting=0. in_req=1 -> ARMED. A press pulse in IDLE is discarded (no buffering).
//   ARMED   : waiting=1. press=1 -> CAPTURE; the synchronised switches are registered this cycle.
//             in_req=0 (cancel) -> IDLE with no strobe.
//   CAPTURE : dataIN <= extended registered switches; in_valid=1 for this cycle only -> DONE.
//   DONE    : waiting=0. Stay until in_req=0 -> IDLE. The processor drops in_req in the cycle
//             after in_valid.
//  Latency: press pulse in ARMED -> in_valid 1 cycle later. Raw key edge -> press pulse is
//    2 + DEBOUNCE_CYCLES cycles (+1 for the edge register) when the key is bounce-free.
//  Simultaneous events: in_req rising in the same cycle as a press pulse while in IDLE -> press
//    is ignored, FSM goes to ARMED. Cancel and press in the same cycle in ARMED -> cancel wins, no capture.
//  Width: extension uses bit SW_WIDTH-1 when SIGN_EXTEND=1. Example: 15'h7FFF -> 32'hFFFF_FFFF;
//    15'h3FFF -> 32'h0000_3FFF.
//  Reset mid-operation: reset in any state returns every register to its reset value next edge.
//    A pending request is lost and the processor must re-issue it.
//  Switch changes after capture do not affect dataIN.
// STRUCTURE
//  Shared package io_pkg: FSM state encoding (IDLE, ARMED, CAPTURE, DONE, 2 bits),
//    SW_WIDTH / DATA_WIDTH defaults, and the debounce default for 50 MHz.
//  Sub-module button_debouncer: 2-flop synchroniser + stable counter + falling-edge pulse,
//    parameterised by DEBOUNCE_CYCLES; one instance for enter.
//  Top level holds the switch synchroniser, the capture register, the FSM and the extension logic.
// TESTING  (DEBOUNCE_CYCLES=4 unless stated)
//  1 reset held 3 cycles, then released -> in_valid=0, waiting=0, dataIN=0.
//  2 in_req=1, switches=15'h0005, clean press -> waiting=1 until capture; exactly one in_valid with
//    dataIN=32'h0000_0005, 1 cycle after the press pulse.
//  3 switches=15'h7FFE with SIGN_EXTEND=1 -> dataIN=32'hFFFF_FFFE; with SIGN_EXTEND=0 -> 32'h0000_7FFE.
//  4 key bounces 1-2-1-3 cycles then holds low 10 cycles, with in_req=1 -> exactly one in_valid;
//    holding the key across a second request -> no capture until release and a fresh press.
//  5 press while IDLE, then in_req -> no strobe; in_req dropped while ARMED -> waiting=0, no strobe.
//  6 reset asserted in CAPTURE -> in_valid=0 and dataIN=0 next edge, FSM in IDLE.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the board I/O ports: request FSM encoding and default sizing.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int SW_WIDTH_DEF       = 15;
    localparam int DATA_WIDTH_DEF     = 32;
    // 10 ms of stable level at a 50 MHz system clock.
    localparam int DEBOUNCE_CYCLES_50 = 500000;

endpackage

// File: rtl/button_debouncer.sv
// Active-low push-button conditioner: 2-flop synchroniser, stable-level counter and
// a single-cycle pulse on each accepted press (debounced 1->0 edge).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = io_pkg::DEBOUNCE_CYCLES_50
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync_q;
    logic             last_q;
    logic             level_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= 2'b11;
            last_q  <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            last_q  <= sync_q[1];
            press_q <= 1'b0;
            // Any bounce, or agreement with the accepted level, restarts the stability window.
            if ((sync_q[1] != last_q) || (sync_q[1] == level_q)) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
                press_q <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/switch_input_port.sv
// Serves the processor IN instruction: waits for a debounced enter press, samples the
// synchronised switches and returns an extended word with a one-cycle valid strobe.
module switch_input_port
    import io_pkg::*;
#(
    parameter int SW_WIDTH        = SW_WIDTH_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50,
    parameter int SIGN_EXTEND     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enter,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic                  in_req,
    output logic                  in_valid,
    output logic [DATA_WIDTH-1:0] dataIN,
    output logic                  waiting
);

    localparam int EXT_W = DATA_WIDTH - SW_WIDTH;

    state_t              state_q;
    logic [SW_WIDTH-1:0] sw_meta_q;
    logic [SW_WIDTH-1:0] sw_sync_q;
    logic [SW_WIDTH-1:0] cap_q;
    logic                in_valid_q;
    logic                waiting_q;
    logic                press;
    logic                ext_bit;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_deb (
        .clock(clock),
        .reset(reset),
        .key_n(enter),
        .press(press)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            cap_q      <= '0;
            in_valid_q <= 1'b0;
            waiting_q  <= 1'b0;
        end else begin
            sw_meta_q  <= switches;
            sw_sync_q  <= sw_meta_q;
            in_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A press seen here is dropped; only a press while armed captures.
                    if (in_req) begin
                        state_q   <= ARMED;
                        waiting_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!in_req) begin
                        state_q   <= IDLE;
                        waiting_q <= 1'b0;
                    end else if (press) begin
                        state_q    <= CAPTURE;
                        cap_q      <= sw_sync_q;
                        in_valid_q <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state_q   <= DONE;
                    waiting_q <= 1'b0;
                end
                DONE: begin
                    if (!in_req) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ext_bit  = (SIGN_EXTEND != 0) && cap_q[SW_WIDTH-1];
    assign dataIN   = {{EXT_W{ext_bit}}, cap_q};
    assign in_valid = in_valid_q;
    assign waiting  = waiting_q;

endmodule
